// File: rtl/vga_game_window_pkg.sv
// Shared VGA 640x480@60 timing constants and game window defaults.
// No logic; holds constants and a small helper function only.
package vga_game_window_pkg;

  function automatic int axis_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_H_TOTAL   = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL   = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  localparam int DEF_GAME_W    = 224;
  localparam int DEF_GAME_H    = 288;
  localparam int DEF_SCALE     = 1;
  localparam int DEF_H_OFFSET  = 208;
  localparam int DEF_V_OFFSET  = 96;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, sync/visible/window decode and game-coordinate mapping.
// Decodes are combinational on the held count; state advances on en; free-running, no backpressure.
module vga_axis_counter
  import vga_game_window_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK,
  parameter int OFFSET  = DEF_H_OFFSET,
  parameter int SIZE    = DEF_GAME_W,
  parameter int SCALE   = DEF_SCALE,
  parameter int CNT_W   = $clog2(axis_total(VISIBLE, FRONT, SYNC, BACK)),
  parameter int SUB_W   = 1,
  parameter int CW      = $clog2(SIZE)
) (
  input  logic             vga_pix_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             sync_n,
  output logic             vis,
  output logic             win,
  output logic             sub_zero,
  output logic [CW-1:0]    coord
);

  localparam int TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int SYNC_LO = VISIBLE + FRONT;
  localparam int SYNC_HI = SYNC_LO + SYNC;
  localparam int WIN_HI  = OFFSET + SIZE * SCALE;

  logic [CNT_W-1:0] count_nxt;
  logic [SUB_W-1:0] sub;

  assign count_nxt = (count == CNT_W'(TOTAL - 1)) ? '0 : count + CNT_W'(1);

  assign sync_n   = !(int'(count) >= SYNC_LO && int'(count) < SYNC_HI);
  assign vis      = int'(count) < VISIBLE;
  assign win      = int'(count) >= OFFSET && int'(count) < WIN_HI;
  assign sub_zero = sub == '0;

  // sub/coord describe the position held in count; they are zeroed on entry to the window
  // so stale values left past the window edge never leak into the next line or frame.
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sub   <= '0;
      coord <= '0;
    end else if (en) begin
      count <= count_nxt;
      if (count_nxt == CNT_W'(OFFSET)) begin
        sub   <= '0;
        coord <= '0;
      end else if (win) begin
        if (sub == SUB_W'(SCALE - 1)) begin
          sub   <= '0;
          coord <= coord + CW'(1);
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_game_window.sv
// VGA 640x480@60 timing plus mapping of the raster onto the scaled, offset game window.
// All outputs registered (1 cycle after the counter state); no backpressure. GAME_WINDOW_FRAME_CNT_EN adds frame_cnt.
module vga_game_window
  import vga_game_window_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int GAME_W    = DEF_GAME_W,
  parameter int GAME_H    = DEF_GAME_H,
  parameter int SCALE     = DEF_SCALE,
  parameter int H_OFFSET  = DEF_H_OFFSET,
  parameter int V_OFFSET  = DEF_V_OFFSET
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst_n,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      vga_de,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic                      display_enabled
`ifdef GAME_WINDOW_FRAME_CNT_EN
  ,
  output logic [7:0]                frame_cnt
`endif
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);
  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int SX_W    = $clog2(GAME_W);
  localparam int SY_W    = $clog2(GAME_H);

  if (SCALE < 1) begin : g_bad_scale
    $error("vga_game_window: SCALE must be >= 1");
  end
  if (H_OFFSET + GAME_W * SCALE > H_VISIBLE) begin : g_bad_h_window
    $error("vga_game_window: game window exceeds visible width");
  end
  if (V_OFFSET + GAME_H * SCALE > V_VISIBLE) begin : g_bad_v_window
    $error("vga_game_window: game window exceeds visible height");
  end

  logic [H_CNT_W-1:0] hcount;
  logic [V_CNT_W-1:0] vcount;
  logic               h_sync_n, h_vis, h_win, h_sub_zero;
  logic               v_sync_n, v_vis, v_win, v_sub_zero;
  logic [SX_W-1:0]    h_coord;
  logic [SY_W-1:0]    v_coord;
  logic               line_end, in_window, frame_start;

  assign line_end    = hcount == H_CNT_W'(H_TOTAL - 1);
  assign in_window   = h_win & v_win;
  assign frame_start = (hcount == '0) && (vcount == '0);

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .OFFSET(H_OFFSET), .SIZE(GAME_W), .SCALE(SCALE),
    .CNT_W(H_CNT_W), .SUB_W(SUB_W), .CW(SX_W)
  ) u_h_axis (
    .vga_pix_clk(vga_pix_clk), .rst_n(rst_n), .en(1'b1),
    .count(hcount), .sync_n(h_sync_n), .vis(h_vis), .win(h_win),
    .sub_zero(h_sub_zero), .coord(h_coord)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .OFFSET(V_OFFSET), .SIZE(GAME_H), .SCALE(SCALE),
    .CNT_W(V_CNT_W), .SUB_W(SUB_W), .CW(SY_W)
  ) u_v_axis (
    .vga_pix_clk(vga_pix_clk), .rst_n(rst_n), .en(line_end),
    .count(vcount), .sync_n(v_sync_n), .vis(v_vis), .win(v_win),
    .sub_zero(v_sub_zero), .coord(v_coord)
  );

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync           <= 1'b1;
      vsync           <= 1'b1;
      vga_de          <= 1'b0;
      sx              <= '0;
      sy              <= '0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
      display_enabled <= 1'b0;
    end else begin
      hsync           <= h_sync_n;
      vsync           <= v_sync_n;
      vga_de          <= h_vis & v_vis;
      sx              <= in_window ? h_coord : '0;
      sy              <= in_window ? v_coord : '0;
      game_pix_stb    <= in_window & h_sub_zero & v_sub_zero;
      frame_stb       <= frame_start;
      display_enabled <= in_window;
    end
  end

`ifdef GAME_WINDOW_FRAME_CNT_EN
  // Steps on the same edge that raises frame_stb, so the first frame after reset reads 1.
  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_game_window.sv
// Scoreboarded bench: default-timing DUT plus two shrunken-timing DUTs (SCALE=2 offset 0, SCALE=1 edge-aligned window).
// A divider-based reference model predicts every registered output per cycle.
module tb_vga_game_window;

  typedef struct packed {
    logic        hsync, vsync, de, den, stb, fstb;
    logic [15:0] sx, sy;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, gw, gh, sc, ho, vo;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_d = 1'b1, rst_n_s = 1'b1, rst_n_u = 1'b1;

  logic       d_hsync, d_vsync, d_de, d_stb, d_fstb, d_den;
  logic [7:0] d_sx;
  logic [8:0] d_sy;
  logic       s_hsync, s_vsync, s_de, s_stb, s_fstb, s_den;
  logic [3:0] s_sx;
  logic [2:0] s_sy;
  logic       u_hsync, u_vsync, u_de, u_stb, u_fstb, u_den;
  logic [3:0] u_sx;
  logic [3:0] u_sy;
`ifdef GAME_WINDOW_FRAME_CNT_EN
  logic [7:0] d_fc, s_fc, u_fc;
`endif

  vga_game_window dut_d (
    .vga_pix_clk(clk), .rst_n(rst_n_d), .hsync(d_hsync), .vsync(d_vsync), .vga_de(d_de),
    .sx(d_sx), .sy(d_sy), .game_pix_stb(d_stb), .frame_stb(d_fstb), .display_enabled(d_den)
`ifdef GAME_WINDOW_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_game_window #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(30), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .GAME_W(10), .GAME_H(8), .SCALE(2), .H_OFFSET(0), .V_OFFSET(0)
  ) dut_s (
    .vga_pix_clk(clk), .rst_n(rst_n_s), .hsync(s_hsync), .vsync(s_vsync), .vga_de(s_de),
    .sx(s_sx), .sy(s_sy), .game_pix_stb(s_stb), .frame_stb(s_fstb), .display_enabled(s_den)
`ifdef GAME_WINDOW_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_game_window #(
    .H_VISIBLE(24), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
    .GAME_W(10), .GAME_H(12), .SCALE(1), .H_OFFSET(14), .V_OFFSET(8)
  ) dut_u (
    .vga_pix_clk(clk), .rst_n(rst_n_u), .hsync(u_hsync), .vsync(u_vsync), .vga_de(u_de),
    .sx(u_sx), .sy(u_sy), .game_pix_stb(u_stb), .frame_stb(u_fstb), .display_enabled(u_den)
`ifdef GAME_WINDOW_FRAME_CNT_EN
    , .frame_cnt(u_fc)
`endif
  );

  cfg_t  cfgs [3];
  string names [3] = '{"dflt", "s2", "s1"};
  int    mh [3], mv [3], mfc [3];
  obs_t  sbq [$];
  obs_t  rst_e;
  int    n_checks = 0, n_pass = 0;
  int    st_stb, st_fstb, st_hlo, st_hfirst, st_vlo, st_de, st_den, st_f0;

  function automatic obs_t model(input cfg_t c, input int h, input int v, input int fc);
    obs_t e;
    int   hl, vl;
    logic wh, wv;
    e  = '0;
    hl = c.hv + c.hf;
    vl = c.vv + c.vf;
    e.hsync = !(h >= hl && h < hl + c.hs);
    e.vsync = !(v >= vl && v < vl + c.vs);
    e.de    = (h < c.hv) && (v < c.vv);
    wh = (h >= c.ho) && (h < c.ho + c.gw * c.sc);
    wv = (v >= c.vo) && (v < c.vo + c.gh * c.sc);
    e.den = wh && wv;
    if (e.den) begin
      e.sx  = 16'((h - c.ho) / c.sc);
      e.sy  = 16'((v - c.vo) / c.sc);
      e.stb = ((h - c.ho) % c.sc == 0) && ((v - c.vo) % c.sc == 0);
    end
    e.fstb = (h == 0) && (v == 0);
    e.fc   = 8'(fc);
    return e;
  endfunction

  function automatic obs_t sample(input int w);
    obs_t o;
    o = '0;
    case (w)
      0: begin
        o.hsync = d_hsync; o.vsync = d_vsync; o.de = d_de; o.den = d_den;
        o.stb = d_stb; o.fstb = d_fstb; o.sx = 16'(d_sx); o.sy = 16'(d_sy);
`ifdef GAME_WINDOW_FRAME_CNT_EN
        o.fc = d_fc;
`endif
      end
      1: begin
        o.hsync = s_hsync; o.vsync = s_vsync; o.de = s_de; o.den = s_den;
        o.stb = s_stb; o.fstb = s_fstb; o.sx = 16'(s_sx); o.sy = 16'(s_sy);
`ifdef GAME_WINDOW_FRAME_CNT_EN
        o.fc = s_fc;
`endif
      end
      default: begin
        o.hsync = u_hsync; o.vsync = u_vsync; o.de = u_de; o.den = u_den;
        o.stb = u_stb; o.fstb = u_fstb; o.sx = 16'(u_sx); o.sy = 16'(u_sy);
`ifdef GAME_WINDOW_FRAME_CNT_EN
        o.fc = u_fc;
`endif
      end
    endcase
    return o;
  endfunction

  task automatic model_reset(input int w);
    mh[w] = 0; mv[w] = 0; mfc[w] = 0;
  endtask

  // Pushes the prediction for the held counter position, clocks once, then drains and compares.
  task automatic run_sb(input int w, input int n);
    obs_t e, o;
    int   fcv, htot, vtot;
    htot = cfgs[w].hv + cfgs[w].hf + cfgs[w].hs + cfgs[w].hb;
    vtot = cfgs[w].vv + cfgs[w].vf + cfgs[w].vs + cfgs[w].vb;
    st_stb = 0; st_fstb = 0; st_hlo = 0; st_hfirst = -1; st_vlo = 0; st_de = 0; st_den = 0; st_f0 = 0;
    for (int i = 0; i < n; i++) begin
      if (mh[w] == 0 && mv[w] == 0) mfc[w] = (mfc[w] + 1) % 256;
`ifdef GAME_WINDOW_FRAME_CNT_EN
      fcv = mfc[w];
`else
      fcv = 0;
`endif
      sbq.push_back(model(cfgs[w], mh[w], mv[w], fcv));
      @(posedge clk);
      #1;
      o = sample(w);
      e = sbq.pop_front();
      n_checks++;
      if (o !== e)
        $display("FAIL sb_%s h=%0d v=%0d: got hs=%b vs=%b de=%b den=%b stb=%b fs=%b sx=%0d sy=%0d fc=%0d, want hs=%b vs=%b de=%b den=%b stb=%b fs=%b sx=%0d sy=%0d fc=%0d",
                 names[w], mh[w], mv[w], o.hsync, o.vsync, o.de, o.den, o.stb, o.fstb, o.sx, o.sy, o.fc,
                 e.hsync, e.vsync, e.de, e.den, e.stb, e.fstb, e.sx, e.sy, e.fc);
      else n_pass++;
      if (!o.hsync) begin st_hlo++; if (st_hfirst < 0) st_hfirst = i; end
      if (!o.vsync) st_vlo++;
      if (o.de) st_de++;
      if (o.den) st_den++;
      if (o.stb) st_stb++;
      if (o.fstb) st_fstb++;
      if (i == 0) st_f0 = int'(o.fstb);
      mh[w]++;
      if (mh[w] == htot) begin
        mh[w] = 0;
        mv[w]++;
        if (mv[w] == vtot) mv[w] = 0;
      end
      if (n_checks - n_pass >= 40) break;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    #2;
    rst_n_d = 1'b0; rst_n_s = 1'b0; rst_n_u = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      o = sample(w);
      n_checks++;
      if (o !== rst_e) $display("FAIL reset_%s: got %h want %h", names[w], o, rst_e);
      else n_pass++;
    end
  endtask

  task automatic test_default_lines();
    @(negedge clk);
    rst_n_d = 1'b1;
    model_reset(0);
    run_sb(0, 800);
    n_checks++; if (st_f0 !== 1) $display("FAIL first_frame_stb: got %0d want 1", st_f0); else n_pass++;
    n_checks++; if (st_hfirst !== 656) $display("FAIL hsync_start_l0: got %0d want 656", st_hfirst); else n_pass++;
    n_checks++; if (st_hlo !== 96) $display("FAIL hsync_width_l0: got %0d want 96", st_hlo); else n_pass++;
    n_checks++; if (st_de !== 640) $display("FAIL de_count_l0: got %0d want 640", st_de); else n_pass++;
    n_checks++; if (st_den !== 0) $display("FAIL window_l0: got %0d want 0", st_den); else n_pass++;
    run_sb(0, 800);
    n_checks++; if (st_hfirst !== 656) $display("FAIL line_period: got %0d want 656", st_hfirst); else n_pass++;
    n_checks++; if (st_fstb !== 0) $display("FAIL frame_stb_l1: got %0d want 0", st_fstb); else n_pass++;
  endtask

  task automatic test_scale2_frame();
    @(negedge clk);
    rst_n_s = 1'b1;
    model_reset(1);
    run_sb(1, 2072);
    n_checks++; if (st_stb !== 80) $display("FAIL s2_stb_per_frame: got %0d want 80", st_stb); else n_pass++;
    n_checks++; if (st_den !== 320) $display("FAIL s2_window_px: got %0d want 320", st_den); else n_pass++;
    n_checks++; if (st_vlo !== 112) $display("FAIL s2_vsync_low: got %0d want 112", st_vlo); else n_pass++;
    n_checks++; if (st_de !== 1200) $display("FAIL s2_de_px: got %0d want 1200", st_de); else n_pass++;
    n_checks++; if (st_fstb !== 1) $display("FAIL s2_frame_stb_cnt: got %0d want 1", st_fstb); else n_pass++;
    run_sb(1, 1);
    n_checks++; if (st_f0 !== 1) $display("FAIL s2_frame_period: got %0d want 1", st_f0); else n_pass++;
  endtask

  task automatic test_scale1_edges();
    @(negedge clk);
    rst_n_u = 1'b1;
    model_reset(2);
    run_sb(2, 972);
    n_checks++; if (st_stb !== 120) $display("FAIL s1_stb_per_frame: got %0d want 120", st_stb); else n_pass++;
    n_checks++; if (st_den !== 120) $display("FAIL s1_window_px: got %0d want 120", st_den); else n_pass++;
    n_checks++; if (st_hlo !== 135) $display("FAIL s1_hsync_low: got %0d want 135", st_hlo); else n_pass++;
    run_sb(2, 1);
    n_checks++; if (st_f0 !== 1) $display("FAIL s1_frame_period: got %0d want 1", st_f0); else n_pass++;
  endtask

  task automatic test_midframe_reset();
    obs_t o;
    @(negedge clk);
    rst_n_s = 1'b0;
    #1;
    o = sample(1);
    n_checks++; if (o !== rst_e) $display("FAIL async_reset_a: got %h want %h", o, rst_e); else n_pass++;
    @(negedge clk);
    rst_n_s = 1'b1;
    model_reset(1);
    run_sb(1, 20 * 56 + 30);
    @(negedge clk);
    rst_n_s = 1'b0;
    #1;
    o = sample(1);
    n_checks++; if (o !== rst_e) $display("FAIL async_reset_mid: got %h want %h", o, rst_e); else n_pass++;
    @(posedge clk);
    #1;
    o = sample(1);
    n_checks++; if (o !== rst_e) $display("FAIL reset_held: got %h want %h", o, rst_e); else n_pass++;
    @(negedge clk);
    rst_n_s = 1'b1;
    model_reset(1);
    run_sb(1, 1);
    n_checks++; if (st_f0 !== 1) $display("FAIL restart_frame_stb: got %0d want 1", st_f0); else n_pass++;
    run_sb(1, 2072);
    n_checks++; if (st_stb !== 80) $display("FAIL restart_stb_frame: got %0d want 80", st_stb); else n_pass++;
  endtask

  initial begin
    cfgs[0] = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, gw:224, gh:288, sc:1, ho:208, vo:96};
    cfgs[1] = '{hv:40, hf:4, hs:6, hb:6, vv:30, vf:2, vs:2, vb:3, gw:10, gh:8, sc:2, ho:0, vo:0};
    cfgs[2] = '{hv:24, hf:3, hs:5, hb:4, vv:20, vf:2, vs:3, vb:2, gw:10, gh:12, sc:1, ho:14, vo:8};
    rst_e = '0;
    rst_e.hsync = 1'b1;
    rst_e.vsync = 1'b1;
    test_reset();
    test_default_lines();
    test_scale2_frame();
    test_scale1_edges();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
